demux_port_buffer: RTL and testbench

Sequential 1-to-2 demultiplexer with per-destination buffering, the distribution counterpart of the datapath 2:1 selectors. It accepts one word per handshake from a single producer (ALU/accumulator write-back) and steers it by a select bit into one of two independent 2-entry output queues (output ports 0 and 1). Each queue drains to its own consumer over a valid/ready handshake, so a stalled port never blocks traffic to the other.

---
 rtl/demux_pkg.sv | 19 +
 rtl/demux_fifo2.sv | 72 +++++++
 rtl/demux_port_buffer.sv | 93 +++++++++
 tb/tb_demux_port_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and types for the 1-to-2 demux port buffer
//
// Purpose: select constants, queue depth and the occupancy count type used by
//          demux_fifo2 and demux_port_buffer.
// Ports:   none (package).
package demux_pkg;

    localparam logic PORT0  = 1'b0;
    localparam logic PORT1  = 1'b1;
    localparam int   QDEPTH = 2;

    // Occupancy 0..QDEPTH
    typedef logic [1:0] count_t;

    function automatic logic count_is_full(input count_t c);
        return c == count_t'(QDEPTH);
    endfunction

endpackage

// File: rtl/demux_fifo2.sv
// rtl/demux_fifo2.sv - 2-entry registered FIFO used as one demux output queue
//
// Purpose: per-port queue with 1-bit write/read pointers and a 0..2 count.
//          Head data comes straight from the storage registers (no bypass).
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   push, push_data     write request and word (ignored when full)
//   full                queue holds QDEPTH words
//   pop_ready           consumer accepts the head word
//   valid, head_data    queue non-empty, word at the read pointer
module demux_fifo2
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop_ready,
    output logic             valid,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_q [QDEPTH];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    count_t           count_q;
    count_t           count_d;
    logic             do_push;
    logic             do_pop;

    assign full      = count_is_full(count_q);
    assign valid     = (count_q != '0);
    assign head_data = mem_q[rd_ptr_q];

    // Guards keep the queue consistent even if a caller pushes while full
    // or pops while empty.
    assign do_push = push && !full;
    assign do_pop  = pop_ready && valid;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/demux_port_buffer.sv
// rtl/demux_port_buffer.sv - 1-to-2 demultiplexer with a 2-entry queue per output port
//
// Purpose: accepts one word per in_valid/in_ready handshake and steers it by
//          in_select into the port 0 or port 1 queue; each port drains
//          independently over its own valid/ready handshake.
// Build option: DEMUX_BCAST_EN adds in_bcast, which writes both queues in one
//          handshake and is only accepted when neither queue is full.
// Ports:
//   clock, reset                      rising-edge clock, async active-high reset
//   in_valid, in_ready                producer handshake
//   in_select, in_data                destination (0/1) and word
//   in_bcast                          broadcast to both ports (DEMUX_BCAST_EN only)
//   out0_valid, out0_ready, out0_data port 0 consumer handshake and head word
//   out1_valid, out1_ready, out1_data port 1 consumer handshake and head word
module demux_port_buffer
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_select,
    input  logic [WIDTH-1:0] in_data,
`ifdef DEMUX_BCAST_EN
    input  logic             in_bcast,
`endif
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
);

    logic bcast;
    logic sel0;
    logic sel1;
    logic full0;
    logic full1;
    logic push0;
    logic push1;

`ifdef DEMUX_BCAST_EN
    assign bcast = in_bcast;
`else
    assign bcast = 1'b0;
`endif

    assign sel0 = bcast || (in_select == PORT0);
    assign sel1 = bcast || (in_select == PORT1);

    // Depends only on select/broadcast and registered fullness, so a stalled
    // consumer's ready can never reach the producer combinationally. A
    // broadcast needs room in both queues so it is never half-performed.
    always_comb begin
        in_ready = 1'b0;
        if (bcast) begin
            in_ready = !full0 && !full1;
        end else if (in_select == PORT1) begin
            in_ready = !full1;
        end else begin
            in_ready = !full0;
        end
    end

    assign push0 = in_valid && in_ready && sel0;
    assign push1 = in_valid && in_ready && sel1;

    demux_fifo2 #(.WIDTH(WIDTH)) u_q0 (
        .clock     (clock),
        .reset     (reset),
        .push      (push0),
        .push_data (in_data),
        .full      (full0),
        .pop_ready (out0_ready),
        .valid     (out0_valid),
        .head_data (out0_data)
    );

    demux_fifo2 #(.WIDTH(WIDTH)) u_q1 (
        .clock     (clock),
        .reset     (reset),
        .push      (push1),
        .push_data (in_data),
        .full      (full1),
        .pop_ready (out1_ready),
        .valid     (out1_valid),
        .head_data (out1_data)
    );

endmodule

// File: tb/tb_demux_port_buffer.sv
// tb/tb_demux_port_buffer.sv - scoreboard bench for demux_port_buffer (WIDTH=8)
module tb_demux_port_buffer;

    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_select = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
`ifdef DEMUX_BCAST_EN
    logic             in_bcast = 1'b0;
`endif
    logic             out0_valid;
    logic             out0_ready = 1'b0;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready = 1'b0;
    logic [WIDTH-1:0] out1_data;

    logic [WIDTH-1:0] exp0 [$];
    logic [WIDTH-1:0] exp1 [$];
    int checks = 0;
    int errors = 0;

    demux_port_buffer #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_select  (in_select),
        .in_data    (in_data),
`ifdef DEMUX_BCAST_EN
        .in_bcast   (in_bcast),
`endif
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake pops the scoreboard for that port.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (out0_valid && out0_ready) begin
                    if (exp0.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL port0_unexpected: got %0h, expected no word", out0_data);
                    end else begin
                        check("port0_data", {24'd0, out0_data}, {24'd0, exp0.pop_front()});
                    end
                end
                if (out1_valid && out1_ready) begin
                    if (exp1.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL port1_unexpected: got %0h, expected no word", out1_data);
                    end else begin
                        check("port1_data", {24'd0, out1_data}, {24'd0, exp1.pop_front()});
                    end
                end
            end
        end
    end

    // One handshake attempt; the expected word is queued only if the bench
    // expects acceptance.
    task automatic push(input logic sel, input logic [WIDTH-1:0] d, input logic exp_rdy, input logic bc);
        in_valid  = 1'b1;
        in_select = sel;
        in_data   = d;
`ifdef DEMUX_BCAST_EN
        in_bcast  = bc;
`endif
        @(negedge clock);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        if (exp_rdy) begin
            if (bc) begin
                exp0.push_back(d);
                exp1.push_back(d);
            end else if (sel) begin
                exp1.push_back(d);
            end else begin
                exp0.push_back(d);
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
`ifdef DEMUX_BCAST_EN
        in_bcast = 1'b0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
        check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        check("rst_out0_data", {24'd0, out0_data}, 32'h00);
        check("rst_out1_data", {24'd0, out1_data}, 32'h00);
        in_select = 1'b0;
        #1 check("rst_in_ready_sel0", {31'd0, in_ready}, 32'd1);
        in_select = 1'b1;
        #1 check("rst_in_ready_sel1", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1;

        // Basic routing with one-cycle latency
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        push(1'b0, 8'hA5, 1'b1, 1'b0);
        check("lat_out0_valid", {31'd0, out0_valid}, 32'd1);
        check("lat_out0_head", {24'd0, out0_data}, 32'hA5);
        push(1'b1, 8'h3C, 1'b1, 1'b0);
        check("lat_out1_valid", {31'd0, out1_valid}, 32'd1);
        check("port0_drained", {31'd0, out0_valid}, 32'd0);
        @(posedge clock);
        #1;

        // Fill port 0, held third push, pop and push in the same cycle
        out0_ready = 1'b0;
        push(1'b0, 8'h11, 1'b1, 1'b0);
        push(1'b0, 8'h22, 1'b1, 1'b0);
        in_valid  = 1'b1;
        in_select = 1'b0;
        in_data   = 8'h33;
        @(negedge clock);
        check("full_in_ready_sel0", {31'd0, in_ready}, 32'd0);
        in_select = 1'b1;
        #1 check("full_in_ready_sel1", {31'd0, in_ready}, 32'd1);
        in_select = 1'b0;
        @(posedge clock);
        #1;
        check("held_out0_head", {24'd0, out0_data}, 32'h11);
        out0_ready = 1'b1;
        @(negedge clock);
        check("full_pop_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("after_pop_in_ready", {31'd0, in_ready}, 32'd1);
        exp0.push_back(8'h33);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("count1_push_pop_valid", {31'd0, out0_valid}, 32'd1);
        check("count1_push_pop_head", {24'd0, out0_data}, 32'h33);
        repeat (2) @(posedge clock);
        #1;

        // Port 1 drains while port 0 is full
        out0_ready = 1'b0;
        push(1'b0, 8'h44, 1'b1, 1'b0);
        push(1'b0, 8'h55, 1'b1, 1'b0);
        push(1'b1, 8'h66, 1'b1, 1'b0);
        check("indep_out1_valid", {31'd0, out1_valid}, 32'd1);
        out0_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        // Back-to-back throughput with continuous pop
        push(1'b1, 8'h81, 1'b1, 1'b0);
        push(1'b1, 8'h82, 1'b1, 1'b0);
        push(1'b1, 8'h83, 1'b1, 1'b0);
        repeat (2) @(posedge clock);
        #1;

        // Asynchronous reset while port 1 holds two words
        out1_ready = 1'b0;
        push(1'b1, 8'hA1, 1'b1, 1'b0);
        push(1'b1, 8'hB2, 1'b1, 1'b0);
        check("pre_rst_out1_valid", {31'd0, out1_valid}, 32'd1);
        @(negedge clock);
        #2;
        reset = 1'b1;
        exp0.delete();
        exp1.delete();
        #1;
        check("async_rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        check("async_rst_out1_data", {24'd0, out1_data}, 32'h00);
        @(posedge clock);
        #1;
        reset = 1'b0;
        out1_ready = 1'b1;
        push(1'b1, 8'h7E, 1'b1, 1'b0);
        check("post_rst_head", {24'd0, out1_data}, 32'h7E);
        @(posedge clock);
        #1;
        check("post_rst_alone", {31'd0, out1_valid}, 32'd0);

`ifdef DEMUX_BCAST_EN
        // Broadcast blocked by a full port 1, then accepted into both
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        push(1'b1, 8'h01, 1'b1, 1'b0);
        push(1'b1, 8'h02, 1'b1, 1'b0);
        push(1'b0, 8'hC3, 1'b0, 1'b1);
        check("bcast_blocked_out0", {31'd0, out0_valid}, 32'd0);
        check("bcast_blocked_out1_head", {24'd0, out1_data}, 32'h01);
        out1_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        out0_ready = 1'b1;
        push(1'b0, 8'hC3, 1'b1, 1'b1);
        check("bcast_out0_valid", {31'd0, out0_valid}, 32'd1);
        check("bcast_out1_valid", {31'd0, out1_valid}, 32'd1);
`endif

        // Drain scoreboard with a bounded wait
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (exp0.size() == 0 && exp1.size() == 0) break;
            @(posedge clock);
            #1;
        end
        check("scoreboard_left", exp0.size() + exp1.size(), 32'd0);
        @(posedge clock);
        #1;
        check("final_out0_valid", {31'd0, out0_valid}, 32'd0);
        check("final_out1_valid", {31'd0, out1_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
